bcd_mod_counter: RTL and testbench

- Generic modulo-N time-field counter, the parametrised successor of the fixed 0-59 minute counter; one instance each for seconds, minutes and hours (MODULO 60/60/24).
- Counts on a carry-in from the lower field and on debounced active-low set buttons, now both up and down.
- Supports synchronous preset load; emits a carry to the next field and BCD digits for the HEX decoders.

---
 rtl/bcd_mod_counter.sv | 124 ++++++++++++
 tb/tb_bcd_mod_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_mod_counter.sv
// Modulo-MODULO time-field counter with carry/borrow, preset load and BCD output.
// Optional hold-to-repeat on the set buttons is enabled by defining BCD_AUTO_REPEAT_EN.
module bcd_mod_counter #(
  parameter int MODULO = 60,
  parameter int DIGITS = 2,
  parameter int W      = $clog2(MODULO)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc_in,
  input  logic                btn_up_n,
  input  logic                btn_dn_n,
  input  logic                load,
  input  logic [W-1:0]        load_val,
  output logic [W-1:0]        value,
  output logic [4*DIGITS-1:0] bcd,
  output logic                carry_out,
  output logic                borrow_out
);

  localparam int SW = W + 2;
  localparam int BW = 4 * DIGITS;
  localparam logic signed [SW-1:0] MOD_S = SW'(MODULO);

  logic up_prev;
  logic dn_prev;
  logic up_p;
  logic dn_p;

  // Button history: 1 means released, so a button held through reset still yields one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_prev <= 1'b1;
      dn_prev <= 1'b1;
    end else begin
      up_prev <= btn_up_n;
      dn_prev <= btn_dn_n;
    end
  end

`ifdef BCD_AUTO_REPEAT_EN
  logic [1:0] up_hold;
  logic [1:0] dn_hold;

  // Hold counters saturate at 2; from then on every held cycle is a repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_hold <= 2'd0;
      dn_hold <= 2'd0;
    end else begin
      if (btn_up_n) begin
        up_hold <= 2'd0;
      end else if (up_hold != 2'd2) begin
        up_hold <= up_hold + 2'd1;
      end
      if (btn_dn_n) begin
        dn_hold <= 2'd0;
      end else if (dn_hold != 2'd2) begin
        dn_hold <= dn_hold + 2'd1;
      end
    end
  end

  assign up_p = ~btn_up_n & (up_prev | (up_hold == 2'd2));
  assign dn_p = ~btn_dn_n & (dn_prev | (dn_hold == 2'd2));
`else
  assign up_p = up_prev & ~btn_up_n;
  assign dn_p = dn_prev & ~btn_dn_n;
`endif

  logic signed [SW-1:0] delta;
  logic signed [SW-1:0] sum;
  logic [W-1:0]         wrapped;
  logic                 load_ok;

  // Signed with two guard bits so that -1 and MODULO+1 are both representable.
  always_comb begin
    delta = SW'(inc_in) + SW'(up_p) - SW'(dn_p);
    sum   = $signed({2'b00, value}) + delta;
    if (sum >= MOD_S) begin
      wrapped = W'(sum - MOD_S);
    end else if (sum < 0) begin
      wrapped = W'(sum + MOD_S);
    end else begin
      wrapped = W'(sum);
    end
  end

  assign load_ok = (32'(load_val) < MODULO);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_ok ? load_val : '0;
    end else begin
      value <= wrapped;
    end
  end

  // Only the carry-in can ripple upward; button wraps stay inside this field.
  assign carry_out  = inc_in & ~load & (sum >= MOD_S);
  assign borrow_out = dn_p & ~load & ~inc_in & ~up_p & (value == '0);

  logic [BW+W-1:0] dd;

  // Double-dabble: binary in the low W bits, BCD digits build up above it.
  always_comb begin
    dd         = '0;
    dd[W-1:0]  = value;
    for (int i = 0; i < W; i++) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (dd[W+4*d +: 4] >= 4'd5) begin
          dd[W+4*d +: 4] = dd[W+4*d +: 4] + 4'd3;
        end
      end
      dd = dd << 1;
    end
    bcd = dd[W +: BW];
  end

  a_value_in_range: assert property (@(posedge clk) disable iff (rst) 32'(value) < MODULO);

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: a MODULO=60 and a MODULO=24 instance share stimulus and are
// compared each cycle against a press-length based reference model.
module tb_bcd_mod_counter;

`ifdef BCD_AUTO_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       inc_in;
  logic       btn_up_n;
  logic       btn_dn_n;
  logic       load;
  logic [5:0] lv60;
  logic [4:0] lv24;
  logic [5:0] v60;
  logic [4:0] v24;
  logic [7:0] bcd60;
  logic [7:0] bcd24;
  logic       c60, c24, b60, b24;

  bcd_mod_counter #(.MODULO(60)) dut60 (
    .clk(clk), .rst(rst), .inc_in(inc_in), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .load(load), .load_val(lv60), .value(v60), .bcd(bcd60), .carry_out(c60), .borrow_out(b60)
  );

  bcd_mod_counter #(.MODULO(24)) dut24 (
    .clk(clk), .rst(rst), .inc_in(inc_in), .btn_up_n(btn_up_n), .btn_dn_n(btn_dn_n),
    .load(load), .load_val(lv24), .value(v24), .bcd(bcd24), .carry_out(c24), .borrow_out(b24)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state: counter per instance, consecutive cycles each button has been low
  int mods[2] = '{60, 24};
  int m_val[2];
  int up_len;
  int dn_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int v);
    return 32'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic bit press(input bit low, input int len);
    return low && (len == 0 || (REPEAT && len >= 2));
  endfunction

  task automatic set_idle();
    inc_in = 1'b0; btn_up_n = 1'b1; btn_dn_n = 1'b1; load = 1'b0; lv60 = '0; lv24 = '0;
  endtask

  // driver: apply one cycle of inputs, check outputs mid-cycle, advance the model at the edge
  task automatic cycle(input bit inc, input bit up_n, input bit dn_n, input bit ld, input logic [5:0] lv);
    bit up_p, dn_p;
    int d, v, l, m, nv[2];
    logic [31:0] gv, gb, gc, gr;
    inc_in = inc; btn_up_n = up_n; btn_dn_n = dn_n; load = ld; lv60 = lv; lv24 = lv[4:0];
    @(negedge clk);
    up_p = press(!up_n, up_len);
    dn_p = press(!dn_n, dn_len);
    d = int'(inc) + int'(up_p) - int'(dn_p);
    for (int k = 0; k < 2; k++) begin
      m = mods[k];
      v = m_val[k];
      l = (k == 0) ? int'(lv) : int'(lv[4:0]);
      gv = (k == 0) ? 32'(v60)   : 32'(v24);
      gb = (k == 0) ? 32'(bcd60) : 32'(bcd24);
      gc = (k == 0) ? 32'(c60)   : 32'(c24);
      gr = (k == 0) ? 32'(b60)   : 32'(b24);
      check((k == 0) ? "value60" : "value24", gv, 32'(v));
      check((k == 0) ? "bcd60" : "bcd24", gb, to_bcd(v));
      check((k == 0) ? "carry60" : "carry24", gc, 32'(inc && !ld && (v + d >= m)));
      check((k == 0) ? "borrow60" : "borrow24", gr, 32'(dn_p && !ld && !inc && !up_p && v == 0));
      nv[k] = ld ? ((l < m) ? l : 0) : (((v + d) % m) + m) % m;
    end
    @(posedge clk);
    m_val[0] = nv[0];
    m_val[1] = nv[1];
    up_len = up_n ? 0 : up_len + 1;
    dn_len = dn_n ? 0 : dn_len + 1;
    #1;
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 6'd0);
  endtask

  task automatic load_cycle(input logic [5:0] lv);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, lv);
  endtask

  // asynchronous reset, checked before any clock edge
  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    #1;
    check("rst_value60", 32'(v60), 32'd0);
    check("rst_bcd60", 32'(bcd60), 32'h00);
    check("rst_value24", 32'(v24), 32'd0);
    check("rst_bcd24", 32'(bcd24), 32'h00);
    check("rst_carry", 32'({c60, c24, b60, b24}), 32'd0);
    m_val[0] = 0; m_val[1] = 0; up_len = 0; dn_len = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit ru, rd;
    set_idle();
    rst = 1'b0;
    #2;
    do_reset();

    // mid-count reset from 37
    load_cycle(6'd37);
    idle_cycle();
    do_reset();

    // 59 + carry-in wraps with carry
    load_cycle(6'd59);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 6'd0);
    idle_cycle();

    // 23 + up press on both fields, then held
    load_cycle(6'd23);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    idle_cycle();

    // down press from 0 borrows; with carry-in it cancels
    load_cycle(6'd0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    idle_cycle();
    load_cycle(6'd0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 6'd0);
    idle_cycle();

    // 58 + carry-in + up press, then the same with a load overriding
    load_cycle(6'd58);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 6'd0);
    idle_cycle();
    load_cycle(6'd58);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 6'd12);
    idle_cycle();

    // out-of-range preset, simultaneous up/down presses
    load_cycle(6'd62);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 6'd0);
    idle_cycle();

    // long hold from 10
    load_cycle(6'd10);
    repeat (6) cycle(1'b0, 1'b0, 1'b1, 1'b0, 6'd0);
    idle_cycle();
    repeat (5) cycle(1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    idle_cycle();

    // random traffic
    ru = 1'b1;
    rd = 1'b1;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) ru = ~ru;
      if ($urandom_range(0, 3) == 0) rd = ~rd;
      cycle(bit'($urandom_range(0, 2) == 0), ru, rd, bit'($urandom_range(0, 15) == 0),
            6'($urandom_range(0, 63)));
      if (n == 300) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
